mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the five-stage ARM pipeline, directly downstream of the execute stage. Takes the ALU result, store data and control bits from the EX/MEM pipeline register and runs loads and stores against an external 32-bit SRAM with a fixed wait-state count. While an access is in flight it asserts `freeze` to stall the upstream stages, and it owns the MEM/WB pipeline register that feeds write-back.

## Interface
Parameters:
- `DATA_BASE`, default 1024: byte address that maps to SRAM word 0.
- `ADDR_W`, default 16: SRAM word-address width.
- `WAIT_CYCLES`, default 4: SRAM access cycles per operation; legal range ≥1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wb_en_in`  in  1  instruction writes the register file.
- `mem_r_en`  in  1  load.
- `mem_w_en`  in  1  store.
- `dest_in`  in  4  destination register.
- `alu_res`  in  32  effective byte address, or the ALU result for non-memory instructions.
- `val_rm`  in  32  store data.
- `freeze`  out  1  stall request to PC, IF/ID, ID/EX and EX/MEM.
- `sram_addr`  out  ADDR_W  SRAM word address.
- `sram_dq_o`  out  32  SRAM write data.
- `sram_dq_i`  in  32  SRAM read data.
- `sram_we_n`  out  1  write enable, active low.
- `sram_oe_n`  out  1  output enable, active low.
- `wb_wb_en`  out  1  MEM/WB register: write-back enable.
- `wb_mem_r_en`  out  1  MEM/WB register: selects memory data in write-back.
- `wb_dest`  out  4  MEM/WB register: destination register.
- `wb_alu_res`  out  32  MEM/WB register: ALU result.
- `wb_mem_data`  out  32  MEM/WB register: load data.

## Operation
- A request is `mem_r_en | mem_w_en`. If both are set, the access is treated as a write.
- Address: `sram_addr = (alu_res - DATA_BASE) >> 2`, truncated to `ADDR_W`. The two low bits are ignored. Out-of-range addresses wrap silently.
- FSM states and transitions:
  - `IDLE`: on a request, latch address, store data and op, then go to `ACCESS` with the counter cleared.
  - `ACCESS`: the counter increments each cycle. When it reaches `WAIT_CYCLES-1`, go to `DONE`; on a read, also capture `sram_dq_i` into an internal read register.
  - `DONE`: always return to `IDLE`. Any request present in `DONE` is ignored, because it is the same instruction that was just serviced.
- `freeze` is combinational:
  - 1 in `IDLE` when a request is present.
  - 1 throughout `ACCESS`.
  - 0 in `DONE`.
  - 0 in `IDLE` with no request.
- SRAM drive:
  - `sram_addr` and `sram_dq_o` come from the latched values.
  - `sram_oe_n` is 0 only in `ACCESS` on a read.
  - `sram_we_n` is 0 only in `ACCESS` on a write.
  - Both are 1 in all other states.
- MEM/WB register:
  - When `freeze` = 0, it loads the inputs; `wb_mem_data` loads the read register.
  - When `freeze` = 1, it loads a bubble: `wb_wb_en` = 0 and `wb_mem_r_en` = 0, with the other fields holding their values.
- Stores load `wb_wb_en` from `wb_en_in` as given; decode guarantees this is 0 for stores.
- Upstream holds the EX/MEM outputs stable while `freeze` = 1.

## Timing
- Reset values:
  - All MEM/WB outputs are 0.
  - `sram_addr` and `sram_dq_o` are 0.
  - `sram_we_n` and `sram_oe_n` are 1.
  - State is `IDLE` and the counter is 0.
  - `freeze` follows its combinational rule.
- Non-memory instruction: 1 cycle; `freeze` stays 0 and MEM/WB loads at the next edge.
- Memory instruction arriving at cycle 0:
  - Cycle 0 is `IDLE` with `freeze` = 1.
  - Cycles 1..W are `ACCESS`, where W = `WAIT_CYCLES`.
  - Cycle W+1 is `DONE` with `freeze` = 0.
  - MEM/WB loads at the end of cycle W+1.
  - Total occupancy is W+2 cycles, with W+1 freeze cycles.
- Read data is sampled at the edge that ends the last `ACCESS` cycle.
- Back-to-back memory instructions: the second one enters `IDLE` at cycle W+2 and repeats the sequence. No overlap.
- Reset asserted mid-access:
  - `sram_we_n` and `sram_oe_n` deassert immediately (asynchronous).
  - The partial write is not retried, and MEM/WB clears.

## Structure
- Shared package `arm_pkg` holds:
  - the state enum `mem_state_t` (`IDLE`, `ACCESS`, `DONE`);
  - the `DATA_BASE` default;
  - the SRAM width constants.
- One sub-module, `sram_ctrl`, contains the FSM, counter, address/data latches, read register, SRAM pins and `freeze`.
- The `mem_stage` top adds the MEM/WB register and bubble insertion.

## Test plan
- Non-memory op, `alu_res`=0x1234, `wb_en_in`=1, `dest_in`=5 → `freeze` is never 1; the next cycle shows `wb_alu_res`=0x1234, `wb_dest`=5, `wb_wb_en`=1.
- Store `alu_res`=1028, `val_rm`=0xDEADBEEF, W=4 → `sram_addr`=1, `sram_we_n` low for exactly 4 cycles, `freeze` high for 5 cycles, one bubble per frozen cycle.
- Load from 1028 after the store, SRAM model returns 0xDEADBEEF → after 6 cycles `wb_mem_data`=0xDEADBEEF, `wb_mem_r_en`=1.
- Two consecutive loads at 1024 and 1032 → two separate 6-cycle sequences with addresses 0 and 2, and no access issued in either `DONE` cycle.
- Both enables set at address 1036 → treated as a write: `sram_we_n` low, `sram_oe_n` high throughout.
- `rst` pulsed during the 2nd `ACCESS` cycle of a store → `sram_we_n`=1 within the same cycle, state `IDLE`, all MEM/WB outputs 0.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline memory stage: FSM state encoding,
// default data-segment base and SRAM bus widths.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  // Byte address that maps onto SRAM word 0.
  localparam int DATA_BASE_DEFAULT = 1024;

  localparam int SRAM_DATA_W         = 32;
  localparam int SRAM_ADDR_W_DEFAULT = 16;

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of the EX/MEM inputs, the SRAM pins and the MEM/WB register outputs
// of the memory stage. The slave modport is the stage's own view; the master
// modport is the view of whatever surrounds it (pipeline plus SRAM).
//
// Stall handshake: freeze is a combinational stall request. While freeze is 1
// the upstream stages must hold every EX/MEM field stable; the memory stage
// inserts a bubble into MEM/WB on each such edge. The edge at which freeze is
// 0 is the one where the stage accepts the current EX/MEM contents into MEM/WB.
interface mem_stage_if #(
  parameter int ADDR_W = arm_pkg::SRAM_ADDR_W_DEFAULT
);

  // EX/MEM pipeline register contents
  logic                              wb_en_in;
  logic                              mem_r_en;
  logic                              mem_w_en;
  logic [3:0]                        dest_in;
  logic [31:0]                       alu_res;
  logic [31:0]                       val_rm;

  // Stall request upstream
  logic                              freeze;

  // SRAM pins
  logic [ADDR_W-1:0]                 sram_addr;
  logic [arm_pkg::SRAM_DATA_W-1:0]   sram_dq_o;
  logic [arm_pkg::SRAM_DATA_W-1:0]   sram_dq_i;
  logic                              sram_we_n;
  logic                              sram_oe_n;

  // MEM/WB pipeline register
  logic                              wb_wb_en;
  logic                              wb_mem_r_en;
  logic [3:0]                        wb_dest;
  logic [31:0]                       wb_alu_res;
  logic [31:0]                       wb_mem_data;

  // Current SRAM controller state, for observation only
  arm_pkg::mem_state_t               dbg_state;

  modport slave (
    input  wb_en_in, mem_r_en, mem_w_en, dest_in, alu_res, val_rm,
    input  sram_dq_i,
    output freeze,
    output sram_addr, sram_dq_o, sram_we_n, sram_oe_n,
    output wb_wb_en, wb_mem_r_en, wb_dest, wb_alu_res, wb_mem_data,
    output dbg_state
  );

  modport master (
    output wb_en_in, mem_r_en, mem_w_en, dest_in, alu_res, val_rm,
    output sram_dq_i,
    input  freeze,
    input  sram_addr, sram_dq_o, sram_we_n, sram_oe_n,
    input  wb_wb_en, wb_mem_r_en, wb_dest, wb_alu_res, wb_mem_data,
    input  dbg_state
  );

endinterface

// File: rtl/sram_ctrl.sv
// Fixed-wait-state SRAM controller: latches one request, holds the SRAM
// strobes for WAIT_CYCLES cycles, captures read data on the final access
// edge, then spends one DONE cycle so the same instruction is not reissued.
module sram_ctrl
  import arm_pkg::*;
#(
  parameter int DATA_BASE   = DATA_BASE_DEFAULT,
  parameter int ADDR_W      = SRAM_ADDR_W_DEFAULT,
  parameter int WAIT_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [31:0]            alu_res,
  input  logic [31:0]            val_rm,
  output logic                   freeze,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_o,
  input  logic [SRAM_DATA_W-1:0] sram_dq_i,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic [31:0]            rd_data,
  output mem_state_t             state_o
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  mem_state_t              state;
  mem_state_t              state_next;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_W-1:0]       addr_q;
  logic [SRAM_DATA_W-1:0]  data_q;
  logic                    wr_q;
  logic [31:0]             rd_q;

  logic                    req;
  logic                    last_access;
  logic [31:0]             byte_off;
  logic [ADDR_W-1:0]       word_addr;

  // Both enables set means a write; byte offset from the data base, low two
  // bits dropped, upper bits wrap silently into the SRAM word space.
  assign req         = mem_r_en | mem_w_en;
  assign byte_off    = alu_res - 32'(DATA_BASE);
  assign word_addr   = ADDR_W'(byte_off >> 2);
  assign last_access = (cnt == CNT_W'(WAIT_CYCLES - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and SRAM strobe / stall decode
  always_comb begin
    state_next = state;
    freeze     = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    case (state)
      IDLE: begin
        if (req) begin
          freeze     = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        freeze    = 1'b1;
        sram_we_n = ~wr_q;
        sram_oe_n = wr_q;
        if (last_access) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // The request still visible here is the one just serviced.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latches, wait-state counter and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q <= word_addr;
            data_q <= val_rm;
            wr_q   <= mem_w_en;
            cnt    <= '0;
          end
        end
        ACCESS: begin
          if (last_access) begin
            cnt <= '0;
            if (!wr_q) begin
              rd_q <= sram_dq_i;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sram_addr = addr_q;
  assign sram_dq_o = data_q;
  assign rd_data   = rd_q;
  assign state_o   = state;

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the five-stage ARM pipeline: SRAM controller plus the
// MEM/WB pipeline register, which takes a bubble on every stalled edge.
module mem_stage
  import arm_pkg::*;
#(
  parameter int DATA_BASE   = DATA_BASE_DEFAULT,
  parameter int ADDR_W      = SRAM_ADDR_W_DEFAULT,
  parameter int WAIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  logic        freeze;
  logic [31:0] rd_data;

  sram_ctrl #(
    .DATA_BASE   (DATA_BASE),
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_sram_ctrl (
    .clk       (clk),
    .rst       (rst),
    .mem_r_en  (bus.mem_r_en),
    .mem_w_en  (bus.mem_w_en),
    .alu_res   (bus.alu_res),
    .val_rm    (bus.val_rm),
    .freeze    (freeze),
    .sram_addr (bus.sram_addr),
    .sram_dq_o (bus.sram_dq_o),
    .sram_dq_i (bus.sram_dq_i),
    .sram_we_n (bus.sram_we_n),
    .sram_oe_n (bus.sram_oe_n),
    .rd_data   (rd_data),
    .state_o   (bus.dbg_state)
  );

  assign bus.freeze = freeze;

  // MEM/WB register: load when not stalled, otherwise bubble the control bits
  // and hold the data fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wb_wb_en    <= 1'b0;
      bus.wb_mem_r_en <= 1'b0;
      bus.wb_dest     <= '0;
      bus.wb_alu_res  <= '0;
      bus.wb_mem_data <= '0;
    end else if (freeze) begin
      bus.wb_wb_en    <= 1'b0;
      bus.wb_mem_r_en <= 1'b0;
    end else begin
      bus.wb_wb_en    <= bus.wb_en_in;
      bus.wb_mem_r_en <= bus.mem_r_en;
      bus.wb_dest     <= bus.dest_in;
      bus.wb_alu_res  <= bus.alu_res;
      bus.wb_mem_data <= rd_data;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a behavioural SRAM behind the pins.
module tb_mem_stage;
  import arm_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_stage_if #(.ADDR_W(16)) bus ();

  mem_stage #(
    .DATA_BASE   (1024),
    .ADDR_W      (16),
    .WAIT_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: writes on the edge while we_n is low, reads when oe_n low
  logic [31:0] sram_mem [0:255];
  always @(posedge clk) begin
    if (!bus.sram_we_n) sram_mem[bus.sram_addr[7:0]] <= bus.sram_dq_o;
  end
  assign bus.sram_dq_i = !bus.sram_oe_n ? sram_mem[bus.sram_addr[7:0]] : 32'h0;

  // Per-operation observations filled by run_op
  int          n_cycles;
  int          n_freeze;
  int          n_we;
  int          n_oe;
  int          n_bubble;
  int          n_hold_bad;
  int          n_done_acc;
  logic [15:0] addr_seen;

  // Driver: present one EX/MEM instruction (called #1 after a rising edge),
  // hold it while frozen, return #1 after the edge that loads MEM/WB.
  task automatic run_op(input logic wb_en, input logic r_en, input logic w_en,
                        input logic [3:0] dest, input logic [31:0] alu,
                        input logic [31:0] rm);
    logic [31:0] prev_alu;
    logic        was_frozen;
    bit          done;
    bus.wb_en_in = wb_en;
    bus.mem_r_en = r_en;
    bus.mem_w_en = w_en;
    bus.dest_in  = dest;
    bus.alu_res  = alu;
    bus.val_rm   = rm;
    n_cycles = 0; n_freeze = 0; n_we = 0; n_oe = 0;
    n_bubble = 0; n_hold_bad = 0; n_done_acc = 0;
    addr_seen = 16'hFFFF;
    prev_alu  = bus.wb_alu_res;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      n_cycles++;
      was_frozen = bus.freeze;
      if (bus.freeze) n_freeze++;
      if (!bus.sram_we_n) n_we++;
      if (!bus.sram_oe_n) n_oe++;
      if (!bus.sram_we_n || !bus.sram_oe_n) addr_seen = bus.sram_addr;
      if (bus.dbg_state == DONE && (!bus.sram_we_n || !bus.sram_oe_n)) n_done_acc++;
      if (!bus.freeze) done = 1;
      @(posedge clk);
      #1;
      if (was_frozen) begin
        if (bus.wb_wb_en === 1'b0 && bus.wb_mem_r_en === 1'b0) n_bubble++;
        if (bus.wb_alu_res !== prev_alu) n_hold_bad++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL run_op_timeout: freeze still %b after 40 cycles, expected release", bus.freeze);
    end
  endtask

  task automatic clear_inputs();
    bus.wb_en_in = 0; bus.mem_r_en = 0; bus.mem_w_en = 0;
    bus.dest_in = 0; bus.alu_res = 0; bus.val_rm = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.wb_wb_en !== 1'b0 || bus.wb_mem_r_en !== 1'b0) begin errors++;
      $display("FAIL reset_wb_ctrl: got %b%b expected 00", bus.wb_wb_en, bus.wb_mem_r_en); end
    checks++; if (bus.wb_dest !== 4'h0 || bus.wb_alu_res !== 32'h0 || bus.wb_mem_data !== 32'h0) begin errors++;
      $display("FAIL reset_wb_data: got %h %h %h expected 0 0 0", bus.wb_dest, bus.wb_alu_res, bus.wb_mem_data); end
    checks++; if (bus.sram_addr !== 16'h0 || bus.sram_dq_o !== 32'h0) begin errors++;
      $display("FAIL reset_sram_bus: got %h %h expected 0 0", bus.sram_addr, bus.sram_dq_o); end
    checks++; if (bus.sram_we_n !== 1'b1 || bus.sram_oe_n !== 1'b1) begin errors++;
      $display("FAIL reset_strobes: got we_n=%b oe_n=%b expected 1 1", bus.sram_we_n, bus.sram_oe_n); end
    checks++; if (bus.freeze !== 1'b0 || bus.dbg_state !== IDLE) begin errors++;
      $display("FAIL reset_state: got freeze=%b state=%0d expected 0 0", bus.freeze, bus.dbg_state); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_non_mem();
    run_op(1'b1, 1'b0, 1'b0, 4'd5, 32'h1234, 32'h0);
    checks++; if (n_freeze !== 0 || n_cycles !== 1) begin errors++;
      $display("FAIL nonmem_timing: got freeze=%0d cycles=%0d expected 0 1", n_freeze, n_cycles); end
    checks++; if (bus.wb_alu_res !== 32'h1234 || bus.wb_dest !== 4'd5 || bus.wb_wb_en !== 1'b1) begin errors++;
      $display("FAIL nonmem_wb: got alu=%h dest=%0d wb_en=%b expected 1234 5 1",
               bus.wb_alu_res, bus.wb_dest, bus.wb_wb_en); end
  endtask

  task automatic test_store();
    run_op(1'b0, 1'b0, 1'b1, 4'd7, 32'd1028, 32'hDEADBEEF);
    checks++; if (n_cycles !== 6 || n_freeze !== 5) begin errors++;
      $display("FAIL store_timing: got cycles=%0d freeze=%0d expected 6 5", n_cycles, n_freeze); end
    checks++; if (n_we !== 4 || n_oe !== 0) begin errors++;
      $display("FAIL store_strobes: got we=%0d oe=%0d expected 4 0", n_we, n_oe); end
    checks++; if (addr_seen !== 16'd1) begin errors++;
      $display("FAIL store_addr: got %0d expected 1", addr_seen); end
    checks++; if (n_bubble !== 5 || n_hold_bad !== 0) begin errors++;
      $display("FAIL store_bubbles: got bubbles=%0d hold_bad=%0d expected 5 0", n_bubble, n_hold_bad); end
    checks++; if (bus.wb_alu_res !== 32'd1028 || bus.wb_wb_en !== 1'b0 || bus.wb_dest !== 4'd7) begin errors++;
      $display("FAIL store_wb: got alu=%h wb_en=%b dest=%0d expected 404 0 7",
               bus.wb_alu_res, bus.wb_wb_en, bus.wb_dest); end
    checks++; if (sram_mem[1] !== 32'hDEADBEEF) begin errors++;
      $display("FAIL store_sram: got %h expected deadbeef", sram_mem[1]); end
  endtask

  task automatic test_load();
    run_op(1'b1, 1'b1, 1'b0, 4'd3, 32'd1028, 32'h0);
    checks++; if (n_cycles !== 6 || n_oe !== 4 || n_we !== 0) begin errors++;
      $display("FAIL load_timing: got cycles=%0d oe=%0d we=%0d expected 6 4 0", n_cycles, n_oe, n_we); end
    checks++; if (bus.wb_mem_data !== 32'hDEADBEEF || bus.wb_mem_r_en !== 1'b1) begin errors++;
      $display("FAIL load_data: got %h r_en=%b expected deadbeef 1", bus.wb_mem_data, bus.wb_mem_r_en); end
    checks++; if (bus.wb_dest !== 4'd3 || bus.wb_wb_en !== 1'b1) begin errors++;
      $display("FAIL load_wb: got dest=%0d wb_en=%b expected 3 1", bus.wb_dest, bus.wb_wb_en); end
  endtask

  task automatic test_back_to_back();
    run_op(1'b0, 1'b0, 1'b1, 4'd0, 32'd1024, 32'hA5A50001);
    run_op(1'b0, 1'b0, 1'b1, 4'd0, 32'd1032, 32'h5A5A0002);
    run_op(1'b1, 1'b1, 1'b0, 4'd1, 32'd1024, 32'h0);
    checks++; if (n_cycles !== 6 || addr_seen !== 16'd0 || n_done_acc !== 0) begin errors++;
      $display("FAIL b2b_first: got cycles=%0d addr=%0d done_acc=%0d expected 6 0 0",
               n_cycles, addr_seen, n_done_acc); end
    checks++; if (bus.wb_mem_data !== 32'hA5A50001 || bus.wb_dest !== 4'd1) begin errors++;
      $display("FAIL b2b_first_data: got %h dest=%0d expected a5a50001 1", bus.wb_mem_data, bus.wb_dest); end
    run_op(1'b1, 1'b1, 1'b0, 4'd2, 32'd1032, 32'h0);
    checks++; if (n_cycles !== 6 || addr_seen !== 16'd2 || n_done_acc !== 0) begin errors++;
      $display("FAIL b2b_second: got cycles=%0d addr=%0d done_acc=%0d expected 6 2 0",
               n_cycles, addr_seen, n_done_acc); end
    checks++; if (bus.wb_mem_data !== 32'h5A5A0002 || bus.wb_dest !== 4'd2) begin errors++;
      $display("FAIL b2b_second_data: got %h dest=%0d expected 5a5a0002 2", bus.wb_mem_data, bus.wb_dest); end
  endtask

  task automatic test_both_en();
    run_op(1'b0, 1'b1, 1'b1, 4'd4, 32'd1036, 32'hCAFEF00D);
    checks++; if (n_we !== 4 || n_oe !== 0 || addr_seen !== 16'd3) begin errors++;
      $display("FAIL both_strobes: got we=%0d oe=%0d addr=%0d expected 4 0 3", n_we, n_oe, addr_seen); end
    run_op(1'b1, 1'b1, 1'b0, 4'd9, 32'd1036, 32'h0);
    checks++; if (bus.wb_mem_data !== 32'hCAFEF00D) begin errors++;
      $display("FAIL both_readback: got %h expected cafef00d", bus.wb_mem_data); end
  endtask

  task automatic test_reset_mid();
    int we_low;
    bus.wb_en_in = 1'b0; bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b1;
    bus.dest_in = 4'd6; bus.alu_res = 32'd1040; bus.val_rm = 32'h0BADF00D;
    @(posedge clk); #1;   // first ACCESS cycle
    @(posedge clk); #1;   // second ACCESS cycle
    checks++; if (bus.sram_we_n !== 1'b0 || bus.dbg_state !== ACCESS) begin errors++;
      $display("FAIL rstmid_pre: got we_n=%b state=%0d expected 0 1", bus.sram_we_n, bus.dbg_state); end
    rst = 1'b1;
    #1;
    checks++; if (bus.sram_we_n !== 1'b1 || bus.sram_oe_n !== 1'b1 || bus.dbg_state !== IDLE) begin errors++;
      $display("FAIL rstmid_async: got we_n=%b oe_n=%b state=%0d expected 1 1 0",
               bus.sram_we_n, bus.sram_oe_n, bus.dbg_state); end
    checks++; if (bus.wb_wb_en !== 1'b0 || bus.wb_mem_r_en !== 1'b0 || bus.wb_dest !== 4'h0 ||
                  bus.wb_alu_res !== 32'h0 || bus.wb_mem_data !== 32'h0) begin errors++;
      $display("FAIL rstmid_wb: got %b %b %h %h %h expected all 0", bus.wb_wb_en, bus.wb_mem_r_en,
               bus.wb_dest, bus.wb_alu_res, bus.wb_mem_data); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    we_low = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!bus.sram_we_n) we_low++;
    end
    checks++; if (we_low !== 0) begin errors++;
      $display("FAIL rstmid_no_retry: got %0d write cycles expected 0", we_low); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_non_mem();
    test_store();
    test_load();
    test_back_to_back();
    test_both_en();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
